// File: rtl/axil_mem_master_if.sv
// rtl/axil_mem_master_if.sv - AXI-Lite bus between axil_mem_master and the memory slave
//
// Purpose: bundles the five AXI-Lite channels (AR, R, AW, W, B) used by axil_mem_master.
// Parameters: ADDR_WDTH (word address width), DATA_WDTH (data width),
//             RESP_WDTH (response width, bit 0 = OKAY flag).
// Modports:
//   master - drives ar_valid/ar_address, r_ready, aw_valid/aw_address, w_valid/w_data,
//            b_ready; receives ar_ready, r_valid/r_data/r_resp, aw_ready, w_ready,
//            b_valid/b_resp.
//   slave  - the mirror image of master.
interface axil_mem_master_if #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
);
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_WDTH-1:0] ar_address;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_WDTH-1:0] r_data;
    logic [RESP_WDTH-1:0] r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_WDTH-1:0] aw_address;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_WDTH-1:0] w_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [RESP_WDTH-1:0] b_resp;

    modport master (
        output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready,
        output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );
endinterface

// File: rtl/axil_mem_master.sv
// rtl/axil_mem_master.sv - AXI-Lite master turning single-word commands into bus transactions
//
// Purpose: accepts one read/write command at a time from the sort engine, runs the
// matching AR/R or AW/W/B transaction on the memory slave, and returns the result on a
// valid/ready response port. resp bit 0 == 1 means OKAY, 0 means ERROR.
// Optional feature macro: AXIL_RETRY_EN - when defined, an ERROR response is reissued
// with the same address/data up to MAX_RETRY times before being reported.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_write, cmd_addr, cmd_wdata payload
//   rsp_valid/rsp_ready        response handshake; rsp_rdata (0 for writes), rsp_err
//   bus                        AXI-Lite master modport (axil_mem_master_if)
module axil_mem_master #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_WDTH-1:0] cmd_addr,
    input  logic [DATA_WDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_WDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    axil_mem_master_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        DECIDE,
        RESP
    } state_t;

    state_t               state;
    logic                 wr_q;
    logic [ADDR_WDTH-1:0] addr_q;
    logic [DATA_WDTH-1:0] wdata_q;
    logic [DATA_WDTH-1:0] rdata_q;
    logic                 resp_ok_q;
    logic                 aw_done;
    logic                 w_done;

    logic                 ar_valid_q;
    logic                 r_ready_q;
    logic                 aw_valid_q;
    logic                 w_valid_q;
    logic                 b_ready_q;

    logic                 aw_hs;
    logic                 w_hs;

`ifdef AXIL_RETRY_EN
    localparam int RETRY_WDTH = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_WDTH-1:0] RETRY_MAX = RETRY_WDTH'(MAX_RETRY);
    logic [RETRY_WDTH-1:0] retry_cnt;
`else
    // Without the retry feature MAX_RETRY has no effect; negative values are never legal.
    if (MAX_RETRY < 0) begin : g_max_retry_negative
    end
`endif

    assign bus.ar_valid   = ar_valid_q;
    assign bus.ar_address = addr_q;
    assign bus.r_ready    = r_ready_q;
    assign bus.aw_valid   = aw_valid_q;
    assign bus.aw_address = addr_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.w_data     = wdata_q;
    assign bus.b_ready    = b_ready_q;

    assign aw_hs = aw_valid_q & bus.aw_ready;
    assign w_hs  = w_valid_q & bus.w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_ok_q  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef AXIL_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q      <= cmd_write;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
`ifdef AXIL_RETRY_EN
                        retry_cnt <= '0;
`endif
                        if (cmd_write) begin
                            state      <= WR_ADDR_DATA;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                        end else begin
                            state      <= RD_ADDR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.r_valid) begin
                        rdata_q   <= bus.r_data;
                        resp_ok_q <= bus.r_resp[0];
                        r_ready_q <= 1'b0;
                        state     <= DECIDE;
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently; either may finish first or both together.
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        b_ready_q <= 1'b1;
                        state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.b_valid) begin
                        resp_ok_q <= bus.b_resp[0];
                        b_ready_q <= 1'b0;
                        state     <= DECIDE;
                    end
                end
                DECIDE: begin
`ifdef AXIL_RETRY_EN
                    if (!resp_ok_q && (retry_cnt < RETRY_MAX)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        if (wr_q) begin
                            state      <= WR_ADDR_DATA;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                        end else begin
                            state      <= RD_ADDR;
                            ar_valid_q <= 1'b1;
                        end
                    end else
`endif
                    begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= wr_q ? '0 : rdata_q;
                        rsp_err   <= ~resp_ok_q;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_mem_master.sv
// tb/tb_axil_mem_master.sv - bench for axil_mem_master with a stub AXI-Lite memory slave
module tb_axil_mem_master;

    localparam int ATTEMPTS =
`ifdef AXIL_RETRY_EN
        4;
`else
        1;
`endif
    localparam int ERR_LAT = 3 + 3 * (ATTEMPTS - 1);

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    axil_mem_master_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();

    axil_mem_master #(
        .ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MAX_RETRY(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub memory slave
    logic        always_error;
    logic        r_stall;
    logic [31:0] mem [16];
    logic        rd_pend, aw_got, w_got;
    logic [3:0]  wa_q;
    logic [31:0] wd_q;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic [3:0]  last_ar = '0;
    logic [31:0] last_wdata = '0;
    logic        s_aw_hs, s_w_hs;
    logic [3:0]  wr_addr_eff;
    logic [31:0] wr_data_eff;

    assign s_aw_hs     = bus.aw_valid & bus.aw_ready;
    assign s_w_hs      = bus.w_valid & bus.w_ready;
    assign wr_addr_eff = s_aw_hs ? bus.aw_address : wa_q;
    assign wr_data_eff = s_w_hs ? bus.w_data : wd_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.r_valid <= 1'b0;
            bus.r_data  <= '0;
            bus.r_resp  <= '0;
            bus.b_valid <= 1'b0;
            bus.b_resp  <= '0;
            rd_pend     <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (bus.r_valid && bus.r_ready) bus.r_valid <= 1'b0;
            if (bus.b_valid && bus.b_ready) bus.b_valid <= 1'b0;
            if (rd_pend && !r_stall) begin
                bus.r_valid <= 1'b1;
                rd_pend     <= 1'b0;
            end
            if (bus.ar_valid && bus.ar_ready) begin
                ar_cnt     <= ar_cnt + 1;
                last_ar    <= bus.ar_address;
                bus.r_data <= always_error ? 32'h0 : mem[bus.ar_address];
                bus.r_resp <= always_error ? 1'b0 : 1'b1;
                if (r_stall) rd_pend <= 1'b1;
                else         bus.r_valid <= 1'b1;
            end
            if (s_aw_hs) begin
                aw_cnt <= aw_cnt + 1;
                aw_got <= 1'b1;
                wa_q   <= bus.aw_address;
            end
            if (s_w_hs) begin
                w_cnt      <= w_cnt + 1;
                w_got      <= 1'b1;
                wd_q       <= bus.w_data;
                last_wdata <= bus.w_data;
            end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                bus.b_valid <= 1'b1;
                bus.b_resp  <= always_error ? 1'b0 : 1'b1;
                if (!always_error) mem[wr_addr_eff] <= wr_data_eff;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issues one command, optionally holds rsp_ready low for 'hold' cycles, then consumes it.
    task automatic run_cmd(input string name, input logic wr, input logic [3:0] addr,
                           input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                           output int lat, output logic [31:0] got_rd, output logic got_err);
        @(negedge clk);
        chk({name, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk({name, " rsp timeout"}, 0, 1);
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s hold%0d rsp_valid", name, h), rsp_valid, 1);
            chk($sformatf("%s hold%0d rsp_rdata", name, h), rsp_rdata, exp_rd);
            chk($sformatf("%s hold%0d cmd_ready", name, h), cmd_ready, 0);
            chk($sformatf("%s hold%0d axi valids", name, h),
                {bus.ar_valid, bus.aw_valid, bus.w_valid}, 3'b000);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " rsp_valid dropped"}, rsp_valid, 0);
        chk({name, " cmd_ready after rsp"}, cmd_ready, 1);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_ar;
        int          exp_aw;
        int          exp_w;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat;
        logic [31:0] got_rd;
        logic        got_err;
        int          a0, aw0, w0;
        int          seen;
        string       nm;

        vecs[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 0, 1, 1, 3};
        vecs[1] = '{1'b0, 4'd5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1, 0, 0, 3};
        vecs[2] = '{1'b1, 4'd2,  32'h12345678, 1'b0, 32'h0,        1'b0, 0, 1, 1, 3};
        vecs[3] = '{1'b0, 4'd2,  32'h0,        1'b0, 32'h12345678, 1'b0, 1, 0, 0, 3};
        vecs[4] = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 0, 1, 1, 3};
        vecs[5] = '{1'b0, 4'd15, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1, 0, 0, 3};
        vecs[6] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1, 0, 0, 3};
        vecs[7] = '{1'b0, 4'd2,  32'h0,        1'b1, 32'h0,        1'b1, ATTEMPTS, 0, 0, ERR_LAT};
        vecs[8] = '{1'b1, 4'd3,  32'hA5A5A5A5, 1'b1, 32'h0,        1'b1, 0, ATTEMPTS, ATTEMPTS, ERR_LAT};
        vecs[9] = '{1'b0, 4'd3,  32'h0,        1'b0, 32'h0,        1'b0, 1, 0, 0, 3};

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        rsp_ready    = 1'b0;
        always_error = 1'b0;
        r_stall      = 1'b0;
        bus.ar_ready = 1'b1;
        bus.aw_ready = 1'b1;
        bus.w_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset axi outputs",
            {bus.ar_valid, bus.r_ready, bus.aw_valid, bus.w_valid, bus.b_ready}, 5'b0);

        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("row%0d", i);
            always_error = vecs[i].err;
            a0  = ar_cnt;
            aw0 = aw_cnt;
            w0  = w_cnt;
            run_cmd(nm, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 32'h0, lat, got_rd, got_err);
            chk({nm, " rsp_rdata"}, got_rd, vecs[i].exp_rdata);
            chk({nm, " rsp_err"}, got_err, vecs[i].exp_err);
            chk({nm, " ar count"}, ar_cnt - a0, vecs[i].exp_ar);
            chk({nm, " aw count"}, aw_cnt - aw0, vecs[i].exp_aw);
            chk({nm, " w count"}, w_cnt - w0, vecs[i].exp_w);
            chk({nm, " latency"}, lat, vecs[i].exp_lat);
            if (vecs[i].wr) chk({nm, " w_data"}, last_wdata, vecs[i].wdata);
            else            chk({nm, " ar_address"}, last_ar, vecs[i].addr);
        end
        always_error = 1'b0;

        // Response back-pressure: rsp held for 10 cycles
        run_cmd("hold", 1'b0, 4'd5, 32'h0, 10, 32'hDEADBEEF, lat, got_rd, got_err);
        chk("hold rsp_rdata", got_rd, 32'hDEADBEEF);
        chk("hold rsp_err", got_err, 0);

        // W accepted three cycles before AW
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b1;
        aw0 = aw_cnt;
        w0  = w_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd9;
        cmd_wdata = 32'h0BADF00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("order both valid", {bus.aw_valid, bus.w_valid}, 2'b11);
        @(negedge clk);
        chk("order w dropped", bus.w_valid, 0);
        chk("order w count", w_cnt - w0, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("order aw hold%0d", k), bus.aw_valid, 1);
            chk($sformatf("order no b_ready%0d", k), bus.b_ready, 0);
            chk($sformatf("order w stays low%0d", k), bus.w_valid, 0);
            if (k < 2) @(negedge clk);
        end
        bus.aw_ready = 1'b1;
        @(negedge clk);
        chk("order aw dropped", bus.aw_valid, 0);
        chk("order b_ready", bus.b_ready, 1);
        chk("order aw count", aw_cnt - aw0, 1);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("order rsp_valid", rsp_valid, 1);
        chk("order rsp_err", rsp_err, 0);
        chk("order rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        run_cmd("order readback", 1'b0, 4'd9, 32'h0, 0, 32'h0, lat, got_rd, got_err);
        chk("order readback data", got_rd, 32'h0BADF00D);

        // Asynchronous reset while waiting in RD_DATA
        r_stall = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        while (!bus.r_ready && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("rst reached RD_DATA", bus.r_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst r_ready async", bus.r_ready, 0);
        chk("rst ar_valid async", bus.ar_valid, 0);
        chk("rst rsp_valid async", rsp_valid, 0);
        @(negedge clk);
        r_stall = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("rst cmd_ready after release", cmd_ready, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid || bus.ar_valid || bus.r_ready) seen++;
        end
        chk("rst no stray activity", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
